// File: rtl/tile_sequencer.sv
`timescale 1ns/1ps
// Purpose : per-tile program buffer and sequencer; issues CLR, then replays the program for N passes.
// Latency : first program word reaches the tile 2 cycles after the start edge (CLEAR, then RUN).
// Backpress: stalls (NOP issued, pc held) on an opcode-101 receive until i_mem_rd_valid is high.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge) and asynchronous active-low reset
//   i_prog_we/addr/data    program buffer write port, honoured only in IDLE
//   i_start                begin a run (IDLE only); latches i_pc_end and i_loop_count
//   i_abort                synchronous return to IDLE from any state, no done pulse
//   i_pc_end               last program address of one pass
//   i_loop_count           number of passes (0 behaves as 1)
//   i_mem_rd_valid         data memory read data valid, releases a receive stall
//   o_instruction          64-bit word driven to the tile
//   o_pc, o_iter           current program address, completed passes
//   o_busy, o_done         high in CLEAR/RUN; one-cycle pulse in DONE
//   o_stall_cnt            saturating count of stall cycles in the current run
module tile_sequencer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int LOOP_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_prog_we,
  input  logic [AW-1:0]     i_prog_addr,
  input  logic [63:0]       i_prog_data,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [AW-1:0]     i_pc_end,
  input  logic [LOOP_W-1:0] i_loop_count,
  input  logic              i_mem_rd_valid,
  output logic [63:0]       o_instruction,
  output logic [AW-1:0]     o_pc,
  output logic [LOOP_W-1:0] o_iter,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_stall_cnt
);

  localparam logic [63:0] NOP_WORD = 64'h0000_0000_0000_0007;
  localparam logic [63:0] CLR_WORD = 64'h2000_0000_0000_0007;
  localparam logic [2:0]  OP_RECV  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [63:0]         r_buf [DEPTH];
  logic [AW-1:0]       r_pc;
  logic [LOOP_W-1:0]   r_iter;
  logic [15:0]         r_stall_cnt;
  logic [AW-1:0]       r_pc_end;
  logic [LOOP_W-1:0]   r_loop_cnt;

  logic [63:0]         w_cur_word;
  logic                w_stalled;
  logic                w_at_end;
  logic                w_last_pass;
  logic [LOOP_W:0]     w_passes;
  logic [LOOP_W:0]     w_iter_inc;

  // ---------------------------------------------------------------------------
  // Decode of the current position in the program
  // ---------------------------------------------------------------------------
  assign w_cur_word = r_buf[r_pc];
  assign w_stalled  = (r_state == S_RUN) && (w_cur_word[2:0] == OP_RECV) && !i_mem_rd_valid;
  assign w_at_end   = (r_pc == r_pc_end);

  // One extra bit so iter+1 never wraps before the compare; a loop count of
  // zero still runs the program once.
  assign w_passes    = (r_loop_cnt == '0) ? (LOOP_W+1)'(1) : {1'b0, r_loop_cnt};
  assign w_iter_inc  = {1'b0, r_iter} + (LOOP_W+1)'(1);
  assign w_last_pass = (w_iter_inc >= w_passes);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state (abort overrides every transition)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) w_state_nxt = S_CLEAR;
        end
        S_CLEAR: w_state_nxt = S_RUN;
        S_RUN: begin
          if (!w_stalled && w_at_end && w_last_pass) w_state_nxt = S_DONE;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from state, pc and the buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    o_instruction = NOP_WORD;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_instruction = NOP_WORD;
      end
      S_CLEAR: begin
        o_instruction = CLR_WORD;
        o_busy        = 1'b1;
      end
      S_RUN: begin
        o_instruction = w_stalled ? NOP_WORD : w_cur_word;
        o_busy        = 1'b1;
      end
      S_DONE: begin
        o_done        = 1'b1;
      end
      default: begin
        o_instruction = NOP_WORD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run datapath: pc, pass counter, stall counter and latched run parameters.
  // On abort everything holds so the point of interruption stays visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc        <= '0;
      r_iter      <= '0;
      r_stall_cnt <= '0;
      r_pc_end    <= '0;
      r_loop_cnt  <= '0;
    end else if (!i_abort) begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_pc_end    <= i_pc_end;
            r_loop_cnt  <= i_loop_count;
            r_pc        <= '0;
            r_iter      <= '0;
            r_stall_cnt <= '0;
          end
        end
        S_CLEAR: begin
          r_pc <= '0;
        end
        S_RUN: begin
          if (w_stalled) begin
            if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
          end else if (!w_at_end) begin
            r_pc <= r_pc + AW'(1);
          end else if (!w_last_pass) begin
            r_pc   <= '0;
            r_iter <= w_iter_inc[LOOP_W-1:0];
          end else begin
            // Final word of the final pass: pc stays on pc_end for inspection.
            r_iter <= w_iter_inc[LOOP_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Program buffer: host writes only while idle; contents are not reset.
  // A write in the start cycle lands before RUN reads the buffer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if ((r_state == S_IDLE) && i_prog_we) begin
      r_buf[i_prog_addr] <= i_prog_data;
    end
  end

  assign o_pc        = r_pc;
  assign o_iter      = r_iter;
  assign o_stall_cnt = r_stall_cnt;

endmodule
